// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the fetch port, the data port and the single-port
//               memory port of the memory arbiter.
//               slave  - the arbiter's view.
//               master - the environment's view (requesters plus memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;

    // Instruction-fetch port
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_rdata;
    logic        if_resp_err;

    // Data port
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_rdata;
    logic        d_resp_err;

    // Single-port memory
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port memory between an
//               instruction-fetch requester and a data requester. One access
//               is outstanding at a time; misaligned requests are answered
//               with an error response without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 1          // cycles from mem_en to valid mem_rdata, 1..4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Value of the wait counter in the cycle where mem_rdata is valid
    localparam logic [1:0] c_LAT_LAST = 2'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;

    logic        r_last_d;       // last grant went to the data port
    logic        r_gnt_d;        // outstanding access belongs to the data port
    logic        r_we;           // outstanding access is a store

    logic [31:0] r_if_rdata;
    logic        r_if_err;
    logic [31:0] r_d_rdata;
    logic        r_d_err;

    logic        w_idle;
    logic        w_gnt_d;
    logic        w_if_acc;
    logic        w_d_acc;
    logic        w_acc;
    logic [31:0] w_addr;
    logic        w_mis;
    logic        w_mem_acc;
    logic        w_capture;

    // ------------------------------------------------------------------
    // Arbitration: data wins when alone or when fetch had the last grant
    // ------------------------------------------------------------------
    assign w_idle    = (r_state == ST_IDLE);
    assign w_gnt_d   = bus.d_req_valid & (~bus.if_req_valid | ~r_last_d);
    assign w_if_acc  = w_idle & bus.if_req_valid & ~w_gnt_d;
    assign w_d_acc   = w_idle & w_gnt_d;
    assign w_acc     = w_if_acc | w_d_acc;
    assign w_addr    = w_gnt_d ? bus.d_req_addr : bus.if_req_addr;
    assign w_mis     = (w_addr[1:0] != 2'b00);
    assign w_mem_acc = w_acc & ~w_mis;
    assign w_capture = (r_state == ST_WAIT) && (r_cnt == c_LAT_LAST);

    assign bus.if_req_ready = w_if_acc;
    assign bus.d_req_ready  = w_d_acc;

    // ------------------------------------------------------------------
    // Memory strobes exist only in the cycle of an aligned accept
    // ------------------------------------------------------------------
    assign bus.mem_en    = w_mem_acc;
    assign bus.mem_we    = (w_mem_acc & w_gnt_d & bus.d_req_we) ? bus.d_req_wstrb : 4'b0000;
    assign bus.mem_addr  = w_mem_acc ? {w_addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_wdata = (w_mem_acc & w_gnt_d) ? bus.d_req_wdata : 32'd0;

    // ------------------------------------------------------------------
    // Response outputs: one-cycle pulse in RESP, payload held in registers
    // ------------------------------------------------------------------
    assign bus.if_resp_valid = (r_state == ST_RESP) & ~r_gnt_d;
    assign bus.d_resp_valid  = (r_state == ST_RESP) &  r_gnt_d;
    assign bus.if_resp_rdata = r_if_rdata;
    assign bus.if_resp_err   = r_if_err;
    assign bus.d_resp_rdata  = r_d_rdata;
    assign bus.d_resp_err    = r_d_err;

    // State register and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: misaligned accepts skip the memory wait entirely
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = w_mis ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == c_LAT_LAST) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt + 2'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Grant bookkeeping, recorded on every accept including misaligned ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
            r_gnt_d  <= 1'b0;
            r_we     <= 1'b0;
        end else if (w_acc) begin
            r_last_d <= w_gnt_d;
            r_gnt_d  <= w_gnt_d;
            r_we     <= w_gnt_d & bus.d_req_we;
        end
    end

    // Response payload: error on misaligned accept, memory data on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rdata <= 32'd0;
            r_if_err   <= 1'b0;
            r_d_rdata  <= 32'd0;
            r_d_err    <= 1'b0;
        end else if (w_acc && w_mis) begin
            if (w_gnt_d) begin
                r_d_rdata <= 32'd0;
                r_d_err   <= 1'b1;
            end else begin
                r_if_rdata <= 32'd0;
                r_if_err   <= 1'b1;
            end
        end else if (w_capture) begin
            if (r_gnt_d) begin
                r_d_rdata <= r_we ? 32'd0 : bus.mem_rdata;
                r_d_err   <= 1'b0;
            end else begin
                r_if_rdata <= bus.mem_rdata;
                r_if_err   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a latency-accurate
//               memory model, a response scoreboard, a request vector table
//               and directed sequences for arbitration, spacing and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int NV  = 10;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MEM_LAT(LAT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h0000_0013 : (32'hA000_0000 | (32'(i) << 8) | 32'(i));
    endfunction

    // Memory model: read data appears exactly LAT cycles after mem_en
    logic [31:0] dev_mem [0:127];
    logic [31:0] pipe [1:4];
    bit          dev_init;
    assign bus.mem_rdata = pipe[LAT];

    always @(posedge clk) begin
        if (!dev_init) begin
            for (int i = 0; i < 128; i++) dev_mem[i] <= init_word(i);
            dev_init <= 1'b1;
        end else if (bus.mem_en && bus.mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) dev_mem[bus.mem_addr[8:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        pipe[1] <= bus.mem_en ? dev_mem[bus.mem_addr[8:2]] : 32'hBADB_AD00;
        for (int k = 2; k <= 4; k++) pipe[k] <= pipe[k-1];
    end

    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = 0;
    exp_t        sb[$];
    logic [31:0] ref_mem [0:127];
    vec_t        tv [NV];

    logic        acc_flag;
    logic        acc_is_d;
    int          acc_cyc;
    logic        acc_en;
    logic [3:0]  acc_we;
    int          resp_cnt = 0;
    int          men_cnt  = 0;
    logic [31:0] last_d_exp = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle observation at the falling edge: accepts feed the scoreboard,
    // responses are popped and compared
    task automatic monitor();
        logic        a_if, a_d, mis;
        logic [31:0] addr;
        int          idx;
        exp_t        e;
        acc_flag = 1'b0;
        if (!rst_n) return;
        a_if = bus.if_req_valid & bus.if_req_ready;
        a_d  = bus.d_req_valid & bus.d_req_ready;
        chk("ready_onehot", 32'(bus.if_req_ready & bus.d_req_ready), 32'd0);
        if (bus.mem_en) men_cnt++;
        if (a_if || a_d) begin
            addr     = a_d ? bus.d_req_addr : bus.if_req_addr;
            mis      = (addr[1:0] != 2'b00);
            idx      = int'(addr[8:2]);
            acc_flag = 1'b1;
            acc_is_d = a_d;
            acc_cyc  = cyc;
            acc_en   = bus.mem_en;
            acc_we   = bus.mem_we;
            chk("acc_mem_en", 32'(bus.mem_en), 32'(!mis));
            if (!mis) begin
                chk("acc_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
                if (a_d && bus.d_req_we) chk("acc_mem_wdata", bus.mem_wdata, bus.d_req_wdata);
            end
            e.is_d = a_d;
            e.err  = mis;
            e.due  = cyc + (mis ? 1 : LAT + 1);
            e.rdata = (mis || (a_d && bus.d_req_we)) ? 32'd0 : ref_mem[idx];
            if (!mis && a_d && bus.d_req_we)
                for (int b = 0; b < 4; b++)
                    if (bus.d_req_wstrb[b]) ref_mem[idx][8*b +: 8] = bus.d_req_wdata[8*b +: 8];
            sb.push_back(e);
        end else begin
            chk("idle_mem_strobe", {27'd0, bus.mem_en, bus.mem_we}, 32'd0);
        end
        if (bus.if_resp_valid || bus.d_resp_valid) begin
            resp_cnt++;
            chk("resp_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("resp_valid_pair", {30'd0, bus.d_resp_valid, bus.if_resp_valid},
                    e.is_d ? 32'd2 : 32'd1);
                chk("resp_cycle", 32'(cyc), 32'(e.due));
                chk("resp_rdata", e.is_d ? bus.d_resp_rdata : bus.if_resp_rdata, e.rdata);
                chk("resp_err", 32'(e.is_d ? bus.d_resp_err : bus.if_resp_err), 32'(e.err));
                if (e.is_d) last_d_exp = e.rdata;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_acc(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!acc_flag && n < 20);
        chk({name, "_accepted"}, 32'(acc_flag), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic clear_reqs();
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
    endtask

    function automatic vec_t mk(input logic is_d, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic exp_en, input logic [3:0] exp_we, input logic exp_err);
        vec_t v;
        v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.exp_en = exp_en; v.exp_we = exp_we; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        int c0, snap;

        tv[0] = mk(1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 4'h0, 1'b0);
        tv[1] = mk(1'b1, 1'b1, 32'h0000_0100, 32'hDEADBEEF,  4'h3, 1'b1, 4'h3, 1'b0);
        tv[2] = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 1'b1, 4'h0, 1'b0);
        tv[3] = mk(1'b1, 1'b0, 32'h0000_0102, 32'h0,         4'h0, 1'b0, 4'h0, 1'b1);
        tv[4] = mk(1'b1, 1'b1, 32'h0000_0106, 32'h55AA55AA,  4'hF, 1'b0, 4'h0, 1'b1);
        tv[5] = mk(1'b1, 1'b1, 32'h0000_0108, 32'h12345678,  4'hC, 1'b1, 4'hC, 1'b0);
        tv[6] = mk(1'b1, 1'b0, 32'h0000_00FC, 32'h0,         4'h0, 1'b1, 4'h0, 1'b0);
        tv[7] = mk(1'b0, 1'b0, 32'h0000_0108, 32'h0,         4'h0, 1'b1, 4'h0, 1'b0);
        tv[8] = mk(1'b0, 1'b0, 32'h0000_0021, 32'h0,         4'h0, 1'b0, 4'h0, 1'b1);
        tv[9] = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 4'h0, 1'b0);

        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        bus.if_req_valid = 1'b0; bus.if_req_addr = 32'd0;
        bus.d_req_valid  = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = 32'd0;
        bus.d_req_wdata  = 32'd0; bus.d_req_wstrb = 4'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready",  32'(bus.if_req_ready),  32'd0);
        chk("rst_d_ready",   32'(bus.d_req_ready),   32'd0);
        chk("rst_resp_valid", {30'd0, bus.d_resp_valid, bus.if_resp_valid}, 32'd0);
        chk("rst_errs",      {30'd0, bus.d_resp_err, bus.if_resp_err}, 32'd0);
        chk("rst_if_rdata",  bus.if_resp_rdata, 32'd0);
        chk("rst_d_rdata",   bus.d_resp_rdata,  32'd0);
        chk("rst_mem",       {27'd0, bus.mem_en, bus.mem_we}, 32'd0);

        // Both requesters valid from reset release: data first, then alternate
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0000_0010;
        bus.d_req_valid  = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h0000_0020;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 4; i++) begin
            wait_acc("rr");
            chk("rr_grant", 32'(acc_is_d), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        clear_reqs();
        drain();

        // Back-to-back fetches: accepts LAT+2 apart, one mem_en each
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0000_0040;
        snap = men_cnt;
        wait_acc("b2b");
        c0 = acc_cyc;
        for (int i = 1; i < 3; i++) begin
            wait_acc("b2b");
            chk("b2b_spacing", 32'(acc_cyc - c0), 32'(LAT + 2));
            c0 = acc_cyc;
        end
        clear_reqs();
        drain();
        chk("b2b_mem_en_count", 32'(men_cnt - snap), 32'd3);

        // Reset while the access waits on memory: the response is discarded
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0000_0044;
        wait_acc("rstwait");
        clear_reqs();
        step();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rstwait_if_rdata", bus.if_resp_rdata, 32'd0);
        chk("rstwait_valid", {30'd0, bus.d_resp_valid, bus.if_resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        snap = resp_cnt;
        repeat (8) step();
        chk("rstwait_no_resp", 32'(resp_cnt - snap), 32'd0);

        // Vector table, one request at a time
        for (int i = 0; i < NV; i++) begin
            if (tv[i].is_d) begin
                bus.d_req_we = tv[i].we; bus.d_req_addr = tv[i].addr;
                bus.d_req_wdata = tv[i].wdata; bus.d_req_wstrb = tv[i].wstrb;
                bus.d_req_valid = 1'b1;
            end else begin
                bus.if_req_addr = tv[i].addr;
                bus.if_req_valid = 1'b1;
            end
            wait_acc("vec");
            chk("vec_grant",  32'(acc_is_d), 32'(tv[i].is_d));
            chk("vec_mem_en", 32'(acc_en),   32'(tv[i].exp_en));
            chk("vec_mem_we", 32'(acc_we),   32'(tv[i].exp_we));
            clear_reqs();
            drain();
            chk("vec_err_hold", 32'(tv[i].is_d ? bus.d_resp_err : bus.if_resp_err), 32'(tv[i].exp_err));
        end

        // Data response payload holds across later fetch responses
        chk("d_rdata_hold", bus.d_resp_rdata, last_d_exp);
        chk("d_err_hold",   32'(bus.d_resp_err), 32'd0);
        chk("d_last_load",  last_d_exp, init_word(63));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
